// File: rtl/output_write_arbiter_if.sv
// Requester/output-register bus of the output write arbiter.
// The arbiter takes the slave modport; the requester side (or a bench) takes master.
interface output_write_arbiter_if #(
  parameter int WORD_W = 16,
  parameter int NREQ   = 3
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        req;
  logic [NREQ*WORD_W-1:0] wdata_in;
  logic [NREQ-1:0]        ack;
  logic                   WE;
  logic [WORD_W-1:0]      Wdata;
  logic                   busy;
  logic [GW-1:0]          last_grant;

  modport master (output req, wdata_in, input ack, WE, Wdata, busy, last_grant);
  modport slave  (input req, wdata_in, output ack, WE, Wdata, busy, last_grant);
endinterface

// File: rtl/output_write_arbiter.sv
// Round-robin arbiter sharing the output register between NREQ requesters,
// with a fixed hold window after every write so each value stays visible.
module output_write_arbiter #(
  parameter int WORD_W      = 16,
  parameter int NREQ        = 3,
  parameter int HOLD_CYCLES = 4
)(
  input logic                    clk,
  input logic                    reset,
  output_write_arbiter_if.slave  bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CW-1:0] HOLD_INIT = (HOLD_CYCLES > 0) ? CW'(HOLD_CYCLES - 1) : '0;
  localparam logic [GW-1:0] LG_RST    = GW'(NREQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_HOLD} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [NREQ-1:0]   r_ack;
  logic              r_we;
  logic [WORD_W-1:0] r_wdata;
  logic              r_busy;
  logic [GW-1:0]     r_lg;

  logic              w_any;
  logic [GW-1:0]     w_win;
  logic [WORD_W-1:0] w_wdata;
  logic [NREQ-1:0]   w_onehot;
  int                w_best;
  int                w_dist;

  // Winner = set bit with the smallest round-robin distance past last grant;
  // distances stay in 0..NREQ-1, so non-power-of-two NREQ never wraps out of range.
  always_comb begin
    w_any    = 1'b0;
    w_win    = '0;
    w_wdata  = '0;
    w_onehot = '0;
    w_best   = NREQ;
    w_dist   = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i > int'(r_lg)) ? (i - int'(r_lg) - 1) : (i + NREQ - int'(r_lg) - 1);
      if (bus.req[i] && (w_dist < w_best)) begin
        w_best      = w_dist;
        w_any       = 1'b1;
        w_win       = GW'(i);
        w_wdata     = bus.wdata_in[i*WORD_W +: WORD_W];
        w_onehot    = '0;
        w_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ack   <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_lg    <= LG_RST;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_we <= 1'b0;
          if (w_any) begin
            r_wdata <= w_wdata;
            r_we    <= 1'b1;
            r_ack   <= w_onehot;
            r_lg    <= w_win;
            r_busy  <= 1'b1;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_we  <= 1'b0;
          r_ack <= '0;
          if (HOLD_CYCLES == 0) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt   <= HOLD_INIT;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_we    <= 1'b0;
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack        = r_ack;
  assign bus.WE         = r_we;
  assign bus.Wdata      = r_wdata;
  assign bus.busy       = r_busy;
  assign bus.last_grant = r_lg;
endmodule

// File: tb/tb_output_write_arbiter.sv
// Bench for output_write_arbiter: vector table, directed corner sequences,
// and a randomized run checked against a cycle-timeline reference model.
module tb_output_write_arbiter;
  localparam int W = 16, N = 3, HA = 4, HB = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  output_write_arbiter_if #(.WORD_W(W), .NREQ(N)) ifa();
  output_write_arbiter_if #(.WORD_W(W), .NREQ(N)) ifb();

  output_write_arbiter #(.WORD_W(W), .NREQ(N), .HOLD_CYCLES(HA)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  output_write_arbiter #(.WORD_W(W), .NREQ(N), .HOLD_CYCLES(HB)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  int total = 0, bad = 0;
  int ncyc = 0;
  always @(posedge clk) ncyc++;

  typedef struct {
    logic [2:0]  req;
    logic [47:0] wd;
    logic [2:0]  exp_ack;
    logic [15:0] exp_wd;
    logic [1:0]  exp_lg;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset(input int ncycles);
    @(negedge clk);
    reset = 1'b1;
    ifa.req = '0; ifa.wdata_in = '0;
    ifb.req = '0; ifb.wdata_in = '0;
    repeat (ncycles) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ack_a();
    bit ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (ifa.ack != 0) ok = 1'b1;
    end
    chk("ack_timeout", 48'(ok), 48'd1);
  endtask

  task automatic wait_idle_a();
    bit ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (!ifa.busy) ok = 1'b1;
    end
    chk("idle_timeout", 48'(ok), 48'd1);
  endtask

  // Reference for the random run: pure timeline arithmetic. A grant lands at
  // cycle c when requests were present in cycle c-1 and c-1 is past the end of
  // the previous write's hold window.
  task automatic random_run(input int ncycles);
    logic [2:0]  req_prev = '0;
    logic [15:0] dprev [3];
    logic [15:0] dcur  [3];
    bit          pend  [3];
    int          last = N - 1;
    int          idle_from = 0;
    int          win;
    bit          exp_we, exp_busy;
    for (int i = 0; i < N; i++) begin pend[i] = 0; dcur[i] = '0; dprev[i] = '0; end
    do_reset(2);
    for (int c = 0; c < ncycles; c++) begin
      if (c > 0) @(negedge clk);
      exp_we   = (c - 1 >= idle_from) && (req_prev != 0);
      exp_busy = exp_we || (c < idle_from);
      chk("rnd_we", 48'(ifa.WE), 48'(exp_we));
      chk("rnd_busy", 48'(ifa.busy), 48'(exp_busy));
      if (exp_we) begin
        win = -1;
        for (int k = 1; k <= N; k++)
          if (win < 0 && req_prev[(last + k) % N]) win = (last + k) % N;
        chk("rnd_ack", 48'(ifa.ack), 48'(3'b001 << win));
        chk("rnd_wdata", 48'(ifa.Wdata), 48'(dprev[win]));
        chk("rnd_lg", 48'(ifa.last_grant), 48'(win));
        last = win;
        idle_from = c + 1 + HA;
      end else begin
        chk("rnd_ack_idle", 48'(ifa.ack), 48'd0);
      end
      for (int i = 0; i < N; i++) begin
        if (ifa.ack[i]) pend[i] = 0;
        else if (pend[i] && $urandom_range(0, 39) == 0) pend[i] = 0;
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1;
          dcur[i] = 16'($urandom);
        end
      end
      for (int i = 0; i < N; i++) begin
        ifa.req[i] = pend[i];
        ifa.wdata_in[i*W +: W] = dcur[i];
        dprev[i] = dcur[i];
      end
      req_prev = ifa.req;
    end
    ifa.req = '0;
  endtask

  initial begin
    int t0, t1, t2, nb, nw, g;
    reset = 1'b0;
    ifa.req = '0; ifa.wdata_in = '0;
    ifb.req = '0; ifb.wdata_in = '0;

    vt[0] = '{3'b010, {16'hC001, 16'hB001, 16'hA001}, 3'b010, 16'hB001, 2'd1};
    vt[1] = '{3'b011, {16'hC002, 16'hB002, 16'hA002}, 3'b001, 16'hA002, 2'd0};
    vt[2] = '{3'b110, {16'hC003, 16'hB003, 16'hA003}, 3'b010, 16'hB003, 2'd1};
    vt[3] = '{3'b101, {16'hC004, 16'hB004, 16'hA004}, 3'b100, 16'hC004, 2'd2};
    vt[4] = '{3'b100, {16'hC005, 16'hB005, 16'hA005}, 3'b100, 16'hC005, 2'd2};
    vt[5] = '{3'b011, {16'hC006, 16'hB006, 16'hA006}, 3'b001, 16'hA006, 2'd0};

    // reset with all requests up
    @(negedge clk);
    reset = 1'b1;
    ifa.req = 3'b111; ifa.wdata_in = {16'hCCCC, 16'hBBBB, 16'hAAAA};
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      chk("rst_we", 48'(ifa.WE), 48'd0);
      chk("rst_ack", 48'(ifa.ack), 48'd0);
      chk("rst_wdata", 48'(ifa.Wdata), 48'd0);
      chk("rst_busy", 48'(ifa.busy), 48'd0);
      chk("rst_lg", 48'(ifa.last_grant), 48'd2);
    end
    reset = 1'b0;
    #1;
    chk("rel_we", 48'(ifa.WE), 48'd0);
    chk("rel_lg", 48'(ifa.last_grant), 48'd2);
    chk("rel_busy", 48'(ifa.busy), 48'd0);
    @(negedge clk);
    chk("rel_first_ack", 48'(ifa.ack), 48'b001);
    chk("rel_first_wdata", 48'(ifa.Wdata), 48'hAAAA);
    ifa.req = '0;
    wait_idle_a();

    // vector table, one grant per entry
    do_reset(2);
    for (int v = 0; v < 6; v++) begin
      ifa.req = vt[v].req; ifa.wdata_in = vt[v].wd;
      wait_ack_a();
      chk($sformatf("vec%0d_ack", v), 48'(ifa.ack), 48'(vt[v].exp_ack));
      chk($sformatf("vec%0d_wdata", v), 48'(ifa.Wdata), 48'(vt[v].exp_wd));
      chk($sformatf("vec%0d_lg", v), 48'(ifa.last_grant), 48'(vt[v].exp_lg));
      chk($sformatf("vec%0d_we", v), 48'(ifa.WE), 48'd1);
      ifa.req = '0;
      wait_idle_a();
    end

    // single write: one-cycle WE, five busy cycles, Wdata persists
    do_reset(2);
    ifa.req = 3'b010; ifa.wdata_in = {16'h0, 16'h1234, 16'h0};
    nb = 0; nw = 0;
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      if (n == 0) begin
        chk("single_ack", 48'(ifa.ack), 48'b010);
        chk("single_wdata", 48'(ifa.Wdata), 48'h1234);
        chk("single_lg", 48'(ifa.last_grant), 48'd1);
        ifa.req = '0;
      end
      nb += int'(ifa.busy);
      nw += int'(ifa.WE);
    end
    chk("single_busy_cycles", 48'(nb), 48'd5);
    chk("single_we_cycles", 48'(nw), 48'd1);
    chk("single_wdata_kept", 48'(ifa.Wdata), 48'h1234);

    // contention: order A,B,C with 2+HOLD spacing
    do_reset(2);
    ifa.req = 3'b111; ifa.wdata_in = {16'hCCCC, 16'hBBBB, 16'hAAAA};
    wait_ack_a(); t0 = ncyc;
    chk("cont0_wdata", 48'(ifa.Wdata), 48'hAAAA);
    ifa.req[0] = 1'b0;
    wait_ack_a(); t1 = ncyc;
    chk("cont1_wdata", 48'(ifa.Wdata), 48'hBBBB);
    ifa.req[1] = 1'b0;
    wait_ack_a(); t2 = ncyc;
    chk("cont2_wdata", 48'(ifa.Wdata), 48'hCCCC);
    ifa.req[2] = 1'b0;
    chk("cont_gap01", 48'(t1 - t0), 48'(2 + HA));
    chk("cont_gap12", 48'(t2 - t1), 48'(2 + HA));
    wait_idle_a();

    // fairness with req[0], req[2] held continuously
    do_reset(2);
    ifa.req = 3'b101; ifa.wdata_in = {16'h2222, 16'h1111, 16'h0000};
    for (int k = 0; k < 6; k++) begin
      wait_ack_a();
      g = (k % 2 == 0) ? 0 : 2;
      chk($sformatf("fair%0d_lg", k), 48'(ifa.last_grant), 48'(g));
      chk($sformatf("fair%0d_ack", k), 48'(ifa.ack), 48'(3'b001 << g));
    end
    ifa.req = '0;
    wait_idle_a();

    // HOLD_CYCLES=0 build: WE pulses two cycles apart, busy low for one cycle
    do_reset(2);
    ifb.req = 3'b011; ifb.wdata_in = {16'h0, 16'h0202, 16'h0101};
    @(negedge clk);
    chk("h0_we1", 48'(ifb.WE), 48'd1);
    chk("h0_ack1", 48'(ifb.ack), 48'b001);
    chk("h0_wdata1", 48'(ifb.Wdata), 48'h0101);
    ifb.req[0] = 1'b0;
    @(negedge clk);
    chk("h0_gap_we", 48'(ifb.WE), 48'd0);
    chk("h0_gap_busy", 48'(ifb.busy), 48'd0);
    @(negedge clk);
    chk("h0_we2", 48'(ifb.WE), 48'd1);
    chk("h0_ack2", 48'(ifb.ack), 48'b010);
    chk("h0_wdata2", 48'(ifb.Wdata), 48'h0202);
    chk("h0_busy2", 48'(ifb.busy), 48'd1);
    ifb.req = '0;
    @(negedge clk);
    chk("h0_end_busy", 48'(ifb.busy), 48'd0);

    // reset in HOLD abandons the window; pending req[2] wins first after release
    do_reset(2);
    ifa.req = 3'b001; ifa.wdata_in = {16'hD2D2, 16'h0, 16'h0F0F};
    wait_ack_a();
    ifa.req = 3'b100;
    repeat (2) @(negedge clk);
    chk("hold_busy_pre", 48'(ifa.busy), 48'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("hold_rst_busy", 48'(ifa.busy), 48'd0);
    chk("hold_rst_we", 48'(ifa.WE), 48'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("hold_rel_ack", 48'(ifa.ack), 48'b100);
    chk("hold_rel_wdata", 48'(ifa.Wdata), 48'hD2D2);
    ifa.req = '0;
    wait_idle_a();

    // reset during the WRITE cycle: WE already high, reset values next cycle
    do_reset(2);
    ifa.req = 3'b010; ifa.wdata_in = {16'h0, 16'h5A5A, 16'h0};
    wait_ack_a();
    chk("wr_rst_we_live", 48'(ifa.WE), 48'd1);
    reset = 1'b1; ifa.req = '0;
    @(negedge clk);
    chk("wr_rst_we", 48'(ifa.WE), 48'd0);
    chk("wr_rst_ack", 48'(ifa.ack), 48'd0);
    chk("wr_rst_wdata", 48'(ifa.Wdata), 48'd0);
    chk("wr_rst_lg", 48'(ifa.last_grant), 48'd2);
    reset = 1'b0;

    random_run(1500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
